// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port shared by the fetch unit (master) and the
// instruction memory (slave).
//
// Handshake: the master raises imem_req with imem_addr and holds both stable
// until the slave returns imem_ack for one cycle with imem_rdata valid in that
// same cycle; imem_ack is meaningless while imem_req is low.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential reads, buffers a word while the
// decoder stalls, and discards in-flight data when a redirect arrives.
// Optional feature macro IFU_ALIGN_CHECK_EN: misaligned redirects are dropped
// and flagged in the sticky misalign_err; otherwise low target bits are cleared.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    instr_fetch_unit_if.master         imem,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic [31:0]                instruction,
    output logic                       IRwrite,
    output logic [31:0]                pc,
    output logic                       misalign_err,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        irw_q, irw_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] kill_pc_q, kill_pc_d;
    logic [31:0] buf_q, buf_d;
    logic        misalign_q, misalign_d;

    logic        redir_take;
    logic        redir_bad;
    logic [31:0] redir_target;

`ifdef IFU_ALIGN_CHECK_EN
    assign redir_take   = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_target = redirect_pc;
`else
    logic unused_redir_low;
    assign unused_redir_low = ^redirect_pc[1:0];
    assign redir_take       = redirect_valid;
    assign redir_bad        = 1'b0;
    assign redir_target     = {redirect_pc[31:2], 2'b00};
`endif

    // Next-state and next-output logic; IRwrite defaults low so it only pulses.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        irw_d      = 1'b0;
        pc_d       = pc_q;
        kill_d     = kill_q;
        kill_pc_d  = kill_pc_q;
        buf_d      = buf_q;
        misalign_d = misalign_q | redir_bad;

        case (state_q)
            S_IDLE: begin
                // Any ack arriving here belongs to a request abandoned by reset.
                state_d = S_REQ;
                req_d   = 1'b1;
                addr_d  = RESET_PC;
                kill_d  = 1'b0;
            end
            S_REQ: begin
                if (imem.imem_ack) begin
                    if (redir_take) begin
                        addr_d = redir_target;
                        kill_d = 1'b0;
                    end else if (kill_q) begin
                        addr_d = kill_pc_q;
                        kill_d = 1'b0;
                    end else if (!stall) begin
                        irw_d   = 1'b1;
                        instr_d = imem.imem_rdata;
                        pc_d    = addr_q;
                        addr_d  = addr_q + 32'd4;
                    end else begin
                        // Keep addr_q as the buffered word's address for pc later.
                        buf_d   = imem.imem_rdata;
                        state_d = S_HOLD;
                        req_d   = 1'b0;
                    end
                end else if (redir_take) begin
                    // Address must stay stable until ack; remember where to go.
                    kill_d    = 1'b1;
                    kill_pc_d = redir_target;
                end
            end
            S_HOLD: begin
                if (redir_take) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = redir_target;
                end else if (!stall) begin
                    irw_d   = 1'b1;
                    instr_d = buf_q;
                    pc_d    = addr_q;
                    addr_d  = addr_q + 32'd4;
                    state_d = S_REQ;
                    req_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instr_q    <= 32'd0;
            irw_q      <= 1'b0;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            kill_pc_q  <= RESET_PC;
            buf_q      <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            irw_q      <= irw_d;
            pc_q       <= pc_d;
            kill_q     <= kill_d;
            kill_pc_q  <= kill_pc_d;
            buf_q      <= buf_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instruction    = instr_q;
    assign IRwrite        = irw_q;
    assign pc             = pc_q;
    assign misalign_err   = misalign_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed scoreboard bench for instr_fetch_unit: the memory side is driven
// cycle by cycle, every word expected to be written is queued as {pc, instr}
// and matched when IRwrite pulses.
module tb_instr_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SALT        = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruction;
    logic        IRwrite;
    logic [31:0] pc;
    logic        misalign_err;
    logic [1:0]  state_dbg;

    instr_fetch_unit_if imem_if ();

    instr_fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem_if),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instruction   (instruction),
        .IRwrite       (IRwrite),
        .pc            (pc),
        .misalign_err  (misalign_err),
        .state_dbg     (state_dbg)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard
    logic [63:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (IRwrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("irwrite_unexpected", {31'd0, IRwrite}, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check_val("ir_pc", pc, e[63:32]);
                check_val("ir_instr", instruction, e[31:0]);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic bus(input logic ack, input logic [31:0] data);
        imem_if.imem_ack   = ack;
        imem_if.imem_rdata = data;
    endtask

    task automatic redir(input logic v, input logic [31:0] target);
        redirect_valid = v;
        redirect_pc    = target;
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        stall = 1'b0;
        redir(1'b0, 32'd0);
        bus(1'b0, 32'd0);
        repeat (3) tick();

        // Reset state
        check_val("rst_req", {31'd0, imem_if.imem_req}, 32'd0);
        check_val("rst_addr", imem_if.imem_addr, TB_RESET_PC);
        check_val("rst_instr", instruction, 32'd0);
        check_val("rst_irwrite", {31'd0, IRwrite}, 32'd0);
        check_val("rst_pc", pc, TB_RESET_PC);
        check_val("rst_misalign", {31'd0, misalign_err}, 32'd0);
        check_val("rst_state", {30'd0, state_dbg}, 32'd0);

        rst = 1'b0;
        check_val("idle_req", {31'd0, imem_if.imem_req}, 32'd0);
        tick();
        check_val("first_req", {31'd0, imem_if.imem_req}, 32'd1);
        check_val("first_addr", imem_if.imem_addr, TB_RESET_PC);

        // Back-to-back zero-wait fetches at 0 and 4
        a = TB_RESET_PC;
        for (int k = 0; k < 2; k++) begin
            check_val("seq_req", {31'd0, imem_if.imem_req}, 32'd1);
            check_val("seq_addr", imem_if.imem_addr, a);
            bus(1'b1, a ^ SALT);
            expect_word(a, a ^ SALT);
            tick();
            check_val("seq_irwrite", {31'd0, IRwrite}, 32'd1);
            a = a + 32'd4;
        end

        // Stall at address 8 for three cycles
        check_val("stall_addr", imem_if.imem_addr, 32'h8);
        bus(1'b1, 32'h8 ^ SALT);
        stall = 1'b1;
        expect_word(32'h8, 32'h8 ^ SALT);
        tick();
        bus(1'b0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            check_val("hold_req", {31'd0, imem_if.imem_req}, 32'd0);
            check_val("hold_irwrite", {31'd0, IRwrite}, 32'd0);
            check_val("hold_state", {30'd0, state_dbg}, 32'd2);
            tick();
        end
        check_val("hold_req", {31'd0, imem_if.imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        check_val("release_irwrite", {31'd0, IRwrite}, 32'd1);
        check_val("release_pc", pc, 32'h8);
        check_val("release_req", {31'd0, imem_if.imem_req}, 32'd1);
        check_val("release_addr", imem_if.imem_addr, 32'hC);

        // Fetch 0xC, then kill the pending request at 0x10
        bus(1'b1, 32'hC ^ SALT);
        expect_word(32'hC, 32'hC ^ SALT);
        tick();
        bus(1'b0, 32'd0);
        check_val("kill_pend_addr", imem_if.imem_addr, 32'h10);
        redir(1'b1, 32'h100);
        tick();
        redir(1'b0, 32'd0);
        check_val("kill_hold_addr", imem_if.imem_addr, 32'h10);
        check_val("kill_hold_req", {31'd0, imem_if.imem_req}, 32'd1);
        tick();
        bus(1'b1, 32'h10 ^ SALT);
        tick();
        bus(1'b0, 32'd0);
        check_val("kill_new_addr", imem_if.imem_addr, 32'h100);
        check_val("kill_irwrite", {31'd0, IRwrite}, 32'd0);

        // Redirect in the same cycle as an ack
        bus(1'b1, 32'h100 ^ SALT);
        redir(1'b1, 32'h200);
        tick();
        bus(1'b0, 32'd0);
        redir(1'b0, 32'd0);
        check_val("same_addr", imem_if.imem_addr, 32'h200);
        check_val("same_irwrite", {31'd0, IRwrite}, 32'd0);

        // Two redirects before the kill resolves: latest wins
        redir(1'b1, 32'h300);
        tick();
        redir(1'b1, 32'h400);
        tick();
        redir(1'b0, 32'd0);
        bus(1'b1, 32'h200 ^ SALT);
        tick();
        bus(1'b0, 32'd0);
        check_val("latest_addr", imem_if.imem_addr, 32'h400);

        // Redirect while holding a stalled word
        bus(1'b1, 32'h400 ^ SALT);
        stall = 1'b1;
        tick();
        bus(1'b0, 32'd0);
        check_val("hredir_req0", {31'd0, imem_if.imem_req}, 32'd0);
        redir(1'b1, 32'h500);
        tick();
        redir(1'b0, 32'd0);
        check_val("hredir_req", {31'd0, imem_if.imem_req}, 32'd1);
        check_val("hredir_addr", imem_if.imem_addr, 32'h500);
        tick();
        check_val("stall_req_kept", {31'd0, imem_if.imem_req}, 32'd1);
        check_val("stall_addr_kept", imem_if.imem_addr, 32'h500);
        stall = 1'b0;

        // Address wrap from 0xFFFF_FFFC to 0
        bus(1'b1, 32'h500 ^ SALT);
        redir(1'b1, 32'hFFFF_FFFC);
        tick();
        redir(1'b0, 32'd0);
        check_val("wrap_top", imem_if.imem_addr, 32'hFFFF_FFFC);
        bus(1'b1, 32'hFFFF_FFFC ^ SALT);
        expect_word(32'hFFFF_FFFC, 32'hFFFF_FFFC ^ SALT);
        tick();
        check_val("wrap_zero", imem_if.imem_addr, 32'h0);
        bus(1'b1, SALT);
        expect_word(32'h0, SALT);
        tick();
        bus(1'b0, 32'd0);
        check_val("wrap_next", imem_if.imem_addr, 32'h4);

        // Misaligned redirect to 0x102 while the request at 4 is pending
        redir(1'b1, 32'h102);
        tick();
        redir(1'b0, 32'd0);
        bus(1'b1, 32'h4 ^ SALT);
`ifdef IFU_ALIGN_CHECK_EN
        check_val("misalign_set", {31'd0, misalign_err}, 32'd1);
        expect_word(32'h4, 32'h4 ^ SALT);
        tick();
        bus(1'b0, 32'd0);
        check_val("misalign_next", imem_if.imem_addr, 32'h8);
`else
        check_val("misalign_tied", {31'd0, misalign_err}, 32'd0);
        tick();
        bus(1'b0, 32'd0);
        check_val("misalign_next", imem_if.imem_addr, 32'h100);
`endif

        // Reset during a pending request at 0x40, late ack in IDLE
        bus(1'b1, 32'hDEAD_BEEF);
        redir(1'b1, 32'h40);
        tick();
        bus(1'b0, 32'd0);
        redir(1'b0, 32'd0);
        check_val("pre_rst_addr", imem_if.imem_addr, 32'h40);
        tick();
        rst = 1'b1;
        #1;
        check_val("async_rst_req", {31'd0, imem_if.imem_req}, 32'd0);
        check_val("async_rst_addr", imem_if.imem_addr, TB_RESET_PC);
        tick();
        rst = 1'b0;
        bus(1'b1, 32'h40 ^ SALT);
        tick();
        bus(1'b0, 32'd0);
        check_val("late_ack_req", {31'd0, imem_if.imem_req}, 32'd1);
        check_val("late_ack_addr", imem_if.imem_addr, TB_RESET_PC);
        check_val("late_ack_irwrite", {31'd0, IRwrite}, 32'd0);
        check_val("post_rst_misalign", {31'd0, misalign_err}, 32'd0);
        bus(1'b1, TB_RESET_PC ^ SALT);
        expect_word(TB_RESET_PC, TB_RESET_PC ^ SALT);
        tick();
        bus(1'b0, 32'd0);
        tick();
        tick();

        // Final report
        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  in  1  clock, rising-edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 imem_req  out  1  memory read request; held until imem_ack.
REQ-005 imem_addr  out  32  fetch address; stable while imem_req=1.
REQ-006 imem_ack  in  1  read data valid on imem_rdata this cycle; ignored when imem_req=0.
REQ-007 imem_rdata  in  32  fetched instruction word.
REQ-008 stall  in  1  downstream cannot accept an instruction this cycle.
REQ-009 redirect_valid  in  1  one-cycle branch/jump request.
REQ-010 redirect_pc  in  32  redirect target; sampled when redirect_valid=1.
REQ-011 instruction  out  32  registered instruction word for the instruction register.
REQ-012 IRwrite  out  1  one-cycle pulse: instruction valid, load it now.
REQ-013 pc  out  32  address of the word currently on instruction.
REQ-014 misalign_err  out  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-015 States SHALL be IDLE, REQ, HOLD; all outputs SHALL be registered.
REQ-016 IDLE SHALL last one cycle after reset release, then go to REQ with imem_addr=RESET_PC.
REQ-017 In REQ, imem_req SHALL be 1; imem_addr SHALL NOT change until imem_ack.
REQ-018 Ack in cycle N with stall=0 and no kill: IRwrite=1, instruction=imem_rdata, pc=imem_addr in cycle N+1; imem_addr+4 requested in N+1 (back-to-back, one instruction per cycle at zero-wait memory).
REQ-019 Ack in cycle N with stall=1: the word SHALL be buffered, FSM SHALL go to HOLD, imem_req=0.
REQ-020 In HOLD, IRwrite SHALL stay 0 while stall=1; in the cycle after stall first samples 0, IRwrite=1 with the buffered word and REQ resumes at the next address.
REQ-021 IRwrite SHALL never be 1 for two cycles with the same word; IRwrite SHALL be 0 in every cycle not covered by REQ-018/020.
REQ-022 Redirect in REQ without ack: a kill flag and target SHALL be registered; the outstanding ack's data SHALL be discarded (no IRwrite); the next request SHALL use the target.
REQ-023 Redirect in the same cycle as ack: the data SHALL be discarded; the next request SHALL use redirect_pc.
REQ-024 Redirect in HOLD: the buffered word SHALL be discarded; go to REQ at redirect_pc next cycle regardless of stall.
REQ-025 A second redirect before the kill resolves SHALL overwrite the stored target (latest wins).
REQ-026 Address arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 stall SHALL NOT block issuing requests while in REQ; it only gates IRwrite.

Reset
REQ-028 On rst: state=IDLE, imem_req=0, imem_addr=RESET_PC, instruction=0, IRwrite=0, pc=RESET_PC, misalign_err=0, kill flag cleared.
REQ-029 rst mid-transaction SHALL abandon the request; a late ack after reset release while in IDLE SHALL be ignored.

Configuration
REQ-030 Macro IFU_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 SHALL set misalign_err (sticky until rst) and the redirect SHALL be ignored entirely.
REQ-031 Macro IFU_ALIGN_CHECK_EN undefined: redirect_pc[1:0] SHALL be forced to 00 and misalign_err tied to 0.

Verification
REQ-032 Reset, RESET_PC=0, ack every REQ cycle, rdata=addr^32'hA5A5_0000 -> IRwrite pulses each cycle, pc 0,4,8,... with matching instruction.
REQ-033 Ack at addr 8 with stall=1 for 3 cycles -> no IRwrite, imem_req=0; IRwrite=1, pc=8 one cycle after stall drops; next request addr 12.
REQ-034 Redirect to 32'h100 while request at 0x10 pending, ack 2 cycles later -> 0x10 data never written; next imem_addr=0x100.
REQ-035 Redirect to 0x200 same cycle as ack at 0x20 -> no IRwrite for 0x20; next imem_addr=0x200.
REQ-036 With IFU_ALIGN_CHECK_EN, redirect to 0x102 -> misalign_err=1, sequential fetch continues; without it -> fetch at 0x100.
REQ-037 Assert rst during REQ at 0x40, ack one cycle after release -> ignored, first fetch at RESET_PC, no IRwrite.
